// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbitrating mux with a registered valid/ready output
// and a per-grant burst limit before the pointer rotates.
module rr_mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] f,
  output logic [3:0]        grant,
  output logic              sel0,
  output logic              sel1,
  output logic [3:0]        ack
);

  localparam logic [3:0] LAST = 4'(MAX_BEATS - 1);

  logic              r_busy;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [3:0]        r_cnt;
  logic [3:0]        r_grant;
  logic [DATA_W-1:0] r_f;

  logic [DATA_W-1:0] w_in [4];
  logic [1:0]        w_nxt;
  logic [1:0]        w_ld;
  logic              w_last;

  // First requester at or after start p, scanning upward mod 4.
  function automatic logic [1:0] pick(input logic [3:0] rq,
                                      input logic [1:0] p);
    logic [1:0] n;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      n = p + 2'(k);
      if (rq[n]) pick = n;
    end
  endfunction

  assign w_in[0] = i0;
  assign w_in[1] = i1;
  assign w_in[2] = i2;
  assign w_in[3] = i3;

  assign w_nxt  = r_sel + 2'd1;
  assign w_last = (r_cnt == LAST) || !req[r_sel];

  always_comb begin
    w_ld = pick(req, r_ptr);
    if (r_busy) w_ld = pick(req, w_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_cnt   <= 4'd0;
      r_grant <= 4'd0;
      r_f     <= '0;
    end else if (!r_busy || out_ready) begin
      if (r_busy && !w_last) begin
        r_f   <= w_in[r_sel];
        r_cnt <= r_cnt + 4'd1;
      end else begin
        if (r_busy) r_ptr <= w_nxt;
        if (|req) begin
          r_busy  <= 1'b1;
          r_grant <= 4'b0001 << w_ld;
          r_sel   <= w_ld;
          r_f     <= w_in[w_ld];
          r_cnt   <= 4'd0;
        end else begin
          r_busy  <= 1'b0;
          r_grant <= 4'd0;
        end
      end
    end
  end

  assign out_valid = r_busy;
  assign f         = r_f;
  assign grant     = r_grant;
  assign sel0      = r_sel[0];
  assign sel1      = r_sel[1];
  assign ack       = (r_busy && out_ready) ? r_grant : 4'd0;

endmodule
